// File: rtl/imem_loader.sv
// imem_loader: streams a program into a flat instruction array and holds the core in reset until loaded
module imem_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    input  logic                    reload,
    output logic [DEPTH*DATA_W-1:0] instr_stream,
    output logic                    cpu_rst,
    output logic [ADDR_W:0]         word_count,
    output logic                    truncated,
    output logic                    running
);
    typedef enum logic {LOAD, RUN} state_t;
    state_t state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic accept, at_end;
    assign in_ready = (state == LOAD);
    assign cpu_rst  = (state != RUN);
    assign running  = (state == RUN);
    assign accept   = in_valid && in_ready;
    assign at_end   = (ptr == ADDR_W'(DEPTH - 1));
    // leave LOAD on the final program word or when the array has no room left
    always_comb begin
        state_nxt = state;
        if (state == LOAD && accept && (in_last || at_end))
            state_nxt = RUN;
    end
    // state, pointer, count and storage; reset and reload both discard the program
    always_ff @(posedge clk) begin
        if (!rst || reload) begin
            state      <= LOAD;
            ptr        <= '0;
            word_count <= '0;
            truncated  <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mem[ptr]   <= in_data;
                ptr        <= at_end ? ptr : ptr + ADDR_W'(1);
                word_count <= word_count + (ADDR_W + 1)'(1);
                if (at_end && !in_last)
                    truncated <= 1'b1;
            end
        end
    end
    for (genvar g = 0; g < DEPTH; g++) begin : g_view
        assign instr_stream[g*DATA_W +: DATA_W] = mem[g];
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: vector table, corner sequences and random stimulus against a program-queue model
module tb_imem_loader;
    localparam int DEPTH = 1024;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic clk = 0;
    logic rst = 0, in_valid = 0, in_last = 0, reload = 0;
    logic [DATA_W-1:0] in_data = '0;
    logic in_ready, cpu_rst, truncated, running;
    logic [ADDR_W:0] word_count;
    logic [DEPTH*DATA_W-1:0] instr_stream;

    int checks = 0;
    int failures = 0;

    logic [31:0] prog [$];
    bit m_run, m_trunc;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .reload(reload), .instr_stream(instr_stream), .cpu_rst(cpu_rst),
        .word_count(word_count), .truncated(truncated), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r; bit rl; bit v; logic [31:0] d; bit l;
        int cnt; bit run; bit trunc;
        logic [31:0] w0; logic [31:0] w1; logic [31:0] w2;
    } vec_t;
    vec_t vecs[16];

    function automatic logic [31:0] exp_word(int i);
        return (i < prog.size()) ? prog[i] : 32'h0;
    endfunction

    function automatic logic [31:0] dut_word(int i);
        return instr_stream[i*DATA_W +: DATA_W];
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(bit r, bit rl, bit v, logic [31:0] d, bit l);
        rst = r; reload = rl; in_valid = v; in_data = d; in_last = l;
        if (!r || rl) begin
            prog.delete(); m_run = 0; m_trunc = 0;
        end else if (!m_run && v) begin
            prog.push_back(d);
            if (l || prog.size() == DEPTH) begin
                m_run = 1;
                if (!l) m_trunc = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(string tag);
        int bad = -1;
        chk({tag, ".word_count"}, 64'(word_count), 64'(prog.size()));
        chk({tag, ".running"}, 64'(running), 64'(m_run));
        chk({tag, ".cpu_rst"}, 64'(cpu_rst), 64'(!m_run));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(!m_run));
        chk({tag, ".truncated"}, 64'(truncated), 64'(m_trunc));
        for (int i = 0; i < DEPTH; i++)
            if (dut_word(i) !== exp_word(i)) begin bad = i; break; end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s.stream word %0d actual=%h required=%h", tag, bad, dut_word(bad), exp_word(bad));
        end
    endtask

    initial begin
        //         r  rl v  data          l   cnt run tr  w0            w1            w2
        vecs[0]  = '{0, 0, 0, 32'h0,        0,  0, 0, 0, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1, 0, 1, 32'h20080005, 0,  1, 0, 0, 32'h20080005, 32'h0,        32'h0};
        vecs[2]  = '{1, 0, 0, 32'h11111111, 0,  1, 0, 0, 32'h20080005, 32'h0,        32'h0};
        vecs[3]  = '{1, 0, 0, 32'h22222222, 1,  1, 0, 0, 32'h20080005, 32'h0,        32'h0};
        vecs[4]  = '{1, 0, 1, 32'h20090003, 0,  2, 0, 0, 32'h20080005, 32'h20090003, 32'h0};
        vecs[5]  = '{1, 0, 1, 32'h01095020, 1,  3, 1, 0, 32'h20080005, 32'h20090003, 32'h01095020};
        vecs[6]  = '{1, 0, 1, 32'h12345678, 1,  3, 1, 0, 32'h20080005, 32'h20090003, 32'h01095020};
        vecs[7]  = '{1, 1, 1, 32'hDEADBEEF, 0,  0, 0, 0, 32'h0,        32'h0,        32'h0};
        vecs[8]  = '{1, 0, 1, 32'hAAAA0001, 0,  1, 0, 0, 32'hAAAA0001, 32'h0,        32'h0};
        vecs[9]  = '{1, 0, 1, 32'hAAAA0002, 0,  2, 0, 0, 32'hAAAA0001, 32'hAAAA0002, 32'h0};
        vecs[10] = '{0, 0, 1, 32'hAAAA0003, 1,  0, 0, 0, 32'h0,        32'h0,        32'h0};
        vecs[11] = '{1, 0, 1, 32'h0000CAFE, 1,  1, 1, 0, 32'h0000CAFE, 32'h0,        32'h0};
        vecs[12] = '{1, 1, 0, 32'h0,        0,  0, 0, 0, 32'h0,        32'h0,        32'h0};
        vecs[13] = '{1, 0, 1, 32'h20080005, 0,  1, 0, 0, 32'h20080005, 32'h0,        32'h0};
        vecs[14] = '{1, 0, 1, 32'h20090003, 0,  2, 0, 0, 32'h20080005, 32'h20090003, 32'h0};
        vecs[15] = '{1, 0, 1, 32'h01095020, 1,  3, 1, 0, 32'h20080005, 32'h20090003, 32'h01095020};

        for (int k = 0; k < 16; k++) begin
            drive(vecs[k].r, vecs[k].rl, vecs[k].v, vecs[k].d, vecs[k].l);
            chk($sformatf("vec%0d.word_count", k), 64'(word_count), 64'(vecs[k].cnt));
            chk($sformatf("vec%0d.running", k), 64'(running), 64'(vecs[k].run));
            chk($sformatf("vec%0d.cpu_rst", k), 64'(cpu_rst), 64'(!vecs[k].run));
            chk($sformatf("vec%0d.in_ready", k), 64'(in_ready), 64'(!vecs[k].run));
            chk($sformatf("vec%0d.truncated", k), 64'(truncated), 64'(vecs[k].trunc));
            chk($sformatf("vec%0d.w0", k), 64'(dut_word(0)), 64'(vecs[k].w0));
            chk($sformatf("vec%0d.w1", k), 64'(dut_word(1)), 64'(vecs[k].w1));
            chk($sformatf("vec%0d.w2", k), 64'(dut_word(2)), 64'(vecs[k].w2));
            check_model($sformatf("vec%0d", k));
        end

        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 1, 32'(i), 0);
        chk("trunc.word1023", 64'(dut_word(1023)), 64'h3FF);
        chk("trunc.word_count", 64'(word_count), 64'd1024);
        chk("trunc.truncated", 64'(truncated), 64'd1);
        chk("trunc.running", 64'(running), 64'd1);
        check_model("trunc");
        drive(1, 0, 1, 32'hFFFFFFFF, 1);
        chk("trunc_extra.word0", 64'(dut_word(0)), 64'h0);
        chk("trunc_extra.word_count", 64'(word_count), 64'd1024);
        check_model("trunc_extra");

        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 1, 32'(i) ^ 32'h5A5A0000, i == DEPTH - 1);
        chk("exact.truncated", 64'(truncated), 64'd0);
        chk("exact.running", 64'(running), 64'd1);
        chk("exact.word_count", 64'(word_count), 64'd1024);
        check_model("exact");

        drive(0, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 15) == 0);
            check_model($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Upstream of the single-cycle cpu core: receives a program as a stream of 32-bit words over a valid/ready handshake.
- Stores the words in a 1024-word instruction array.
- Presents the array as the flat 32768-bit instruction stream the core consumes. Word i sits at bits [i*32 +: 32].
- Holds the core in reset while loading and releases it once the program is complete; the program can be reloaded at run time.

Parameters:
- DEPTH, 1024, number of instruction words; must match the core's instruction array.
- ADDR_W, 10, write-pointer width, log2(DEPTH).
- DATA_W, 32, instruction word width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low.
- in_valid  input  1  load beat valid.
- in_data  input  DATA_W  instruction word for the current beat.
- in_last  input  1  current beat is the final program word.
- in_ready  output  1  loader can accept a beat.
- reload  input  1  single-cycle request to discard the program and re-enter loading.
- instr_stream  output  DEPTH*DATA_W  flat instruction array; word i at [i*DATA_W +: DATA_W].
- cpu_rst  output  1  active-high reset to the core; 1 while not running.
- word_count  output  ADDR_W+1  number of words accepted since the last reset or reload (0..1024).
- truncated  output  1  sticky: array filled without in_last seen.
- running  output  1  state == RUN.

Behaviour:
- States: LOAD, RUN. All outputs are registered or decoded from state; there are no combinational input-to-output paths except none.
- Reset (rst==0 at an edge):
  - state=LOAD, write pointer=0, word_count=0.
  - All DEPTH words cleared to 0 (0x00000000 is a NOP for the core).
  - truncated=0, cpu_rst=1, running=0, in_ready=1.
- Decoded outputs:
  - in_ready = (state==LOAD).
  - cpu_rst = (state!=RUN).
  - running = (state==RUN).
- LOAD:
  - A beat is accepted when in_valid && in_ready at a rising edge.
  - On accept: word[ptr] <= in_data, ptr <= ptr+1, word_count <= word_count+1.
  - The written word is visible on instr_stream after that edge (1-cycle latency).
  - Accept with in_last=1 -> RUN at the same edge.
  - Accept at ptr==DEPTH-1 with in_last=0 -> RUN and truncated <= 1. The pointer does not wrap; no further beats are taken.
  - Accept at ptr==DEPTH-1 with in_last=1 -> RUN, truncated stays 0.
  - in_valid=0 -> hold all state; a bubble between beats is legal.
- RUN:
  - in_ready=0; in_valid and in_data are ignored.
  - Array contents are frozen.
  - cpu_rst=0 from the first cycle after the final accepting edge. The core sees reset released with pc=0 and the full program present.
- reload=1 at an edge, in either state:
  - state=LOAD, ptr=0, word_count=0, truncated=0, array cleared to 0, cpu_rst=1 from the next cycle.
  - A beat presented in the same cycle is NOT written; in_ready is still 1 in LOAD, so the source must treat that beat as dropped. Sources must not drive reload and in_valid together.
- Priority per edge: rst > reload > beat accept.
- Reset mid-load: partial program discarded, array cleared, loading restarts at word 0.
- word_count saturates naturally at DEPTH (reached only via truncation or exact fill).
- instr_stream is a direct view of the storage registers. Storage is a register array, not inferred RAM, because every word is read in parallel.

Test Plan:
- Reset then stream 3 beats 0x20080005, 0x20090003, 0x01095020 with in_last on beat 3, no gaps.
  -> instr_stream[31:0]=0x20080005, [63:32]=0x20090003, [95:64]=0x01095020, the rest 0; word_count=3.
  -> cpu_rst falls and running rises on the cycle after beat 3; in_ready=0.
- Same 3 beats with in_valid deasserted for 2 cycles between beats 1 and 2.
  -> identical final contents; word_count increments only on accepted beats; cpu_rst stays 1 until after beat 3.
- Stream 1024 beats (data = index) with in_last=0 throughout.
  -> word 1023 = 0x000003FF, word_count=1024, truncated=1, running=1; a 1025th beat is not accepted and the array is unchanged.
- In RUN after test 1, pulse reload for one cycle with in_valid=1, in_data=0xDEADBEEF.
  -> next cycle: all words 0, word_count=0, cpu_rst=1, in_ready=1; 0xDEADBEEF appears nowhere.
- Assert rst=0 for one edge after 2 of 3 beats.
  -> word_count=0, words 0 and 1 cleared, state LOAD.
  -> a fresh 1-beat load with in_last=1 writes word 0 only and enters RUN.
